// File: rtl/cordic_iter_if.sv
// Operand/result bundle for the iterative CORDIC engine.
// The slave modport is the engine's view. The master modport is the driver/consumer view.
interface cordic_iter_if #(
    parameter int N = 32
);
    logic                in_valid;
    logic                in_ready;
    logic                mode;
    logic                trig;
    logic signed [N-1:0] x_in;
    logic signed [N-1:0] y_in;
    logic signed [N-1:0] z_in;
    logic                out_valid;
    logic                out_ready;
    logic signed [N-1:0] x_out;
    logic signed [N-1:0] y_out;
    logic signed [N-1:0] z_out;
    logic                err;

    modport slave (
        input  in_valid, mode, trig, x_in, y_in, z_in, out_ready,
        output in_ready, out_valid, x_out, y_out, z_out, err
    );

    modport master (
        output in_valid, mode, trig, x_in, y_in, z_in, out_ready,
        input  in_ready, out_valid, x_out, y_out, z_out, err
    );
endinterface

// File: rtl/cordic_iter.sv
// Iterative CORDIC engine that does one micro-rotation per clock.
// All data is signed Q4.(N-4). The X/Y/Z working registers carry two extra integer bits.
// A final SCALE cycle multiplies X and Y by the CORDIC gain correction K and saturates.
module cordic_iter #(
    parameter int N = 32,
    parameter int I = 16
) (
    input  logic          clk,
    input  logic          rst,
    cordic_iter_if.slave  bus
);
    localparam int W  = N + 2;
    localparam int PW = W + N;

    localparam logic [31:0] PI_Q28      = 32'h3243F6A8;
    localparam logic [31:0] HALF_PI_Q28 = 32'h1921FB54;
    localparam logic [31:0] K_Q28       = 32'h09B74EDA;

    // Truncate a positive Q4.28 constant to Q4.(N-4), then zero-extend it to working width.
    function automatic logic signed [W-1:0] q28_to_w(input logic [31:0] v);
        q28_to_w = $signed({2'b00, v[31 -: N]});
    endfunction

    // Table of atan(2^-k) in Q4.28, truncated.
    function automatic logic [31:0] atan_q28(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_q28 = 32'h0C90FDAA;
            5'd1:    atan_q28 = 32'h076B19C1;
            5'd2:    atan_q28 = 32'h03EB6EBF;
            5'd3:    atan_q28 = 32'h01FD5BA9;
            5'd4:    atan_q28 = 32'h00FFAADD;
            5'd5:    atan_q28 = 32'h007FF556;
            5'd6:    atan_q28 = 32'h003FFEAA;
            5'd7:    atan_q28 = 32'h001FFFD5;
            5'd8:    atan_q28 = 32'h000FFFFA;
            5'd9:    atan_q28 = 32'h0007FFFF;
            5'd10:   atan_q28 = 32'h0003FFFF;
            5'd11:   atan_q28 = 32'h0001FFFF;
            5'd12:   atan_q28 = 32'h0000FFFF;
            5'd13:   atan_q28 = 32'h00007FFF;
            5'd14:   atan_q28 = 32'h00003FFF;
            5'd15:   atan_q28 = 32'h00001FFF;
            5'd16:   atan_q28 = 32'h00000FFF;
            5'd17:   atan_q28 = 32'h000007FF;
            5'd18:   atan_q28 = 32'h000003FF;
            5'd19:   atan_q28 = 32'h000001FF;
            5'd20:   atan_q28 = 32'h000000FF;
            5'd21:   atan_q28 = 32'h0000007F;
            5'd22:   atan_q28 = 32'h0000003F;
            5'd23:   atan_q28 = 32'h0000001F;
            5'd24:   atan_q28 = 32'h0000000F;
            5'd25:   atan_q28 = 32'h00000007;
            5'd26:   atan_q28 = 32'h00000003;
            5'd27:   atan_q28 = 32'h00000001;
            default: atan_q28 = 32'h00000000;
        endcase
    endfunction

    // Clamp a wide signed value to the N-bit signed range.
    function automatic logic signed [N-1:0] sat_n(input logic signed [PW-1:0] v);
        logic [PW-N:0] top;
        top = v[PW-1:N-1];
        if ((&top) || !(|top)) begin
            sat_n = v[N-1:0];
        end else begin
            sat_n = {v[PW-1], {(N-1){~v[PW-1]}}};
        end
    endfunction

    localparam logic signed [W-1:0] PI_W      = q28_to_w(PI_Q28);
    localparam logic signed [W-1:0] HALF_PI_W = q28_to_w(HALF_PI_Q28);
    localparam logic signed [N-1:0] K_N       = K_Q28[31 -: N];
    localparam logic signed [W-1:0] ONE_W     = {{(W-N+3){1'b0}}, 1'b1, {(N-4){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          k_q, k_d;
    logic signed [W-1:0] x_q, x_d;
    logic signed [W-1:0] y_q, y_d;
    logic signed [W-1:0] z_q, z_d;
    logic                mode_q, mode_d;
    logic                err_pend_q, err_pend_d;
    logic signed [N-1:0] xo_q, xo_d;
    logic signed [N-1:0] yo_q, yo_d;
    logic signed [N-1:0] zo_q, zo_d;
    logic                err_q, err_d;
    logic                in_ready_q;
    logic                out_valid_q;

    logic signed [W-1:0]  xs_s, ys_s, zin_s;
    logic signed [W-1:0]  xsh_s, ysh_s, atan_s;
    logic                 d_pos_s;
    logic signed [PW-1:0] px_s, py_s, px_sh_s, py_sh_s;

    // Next-state, pre-rotation, micro-rotation and scaling datapath.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        x_d        = x_q;
        y_d        = y_q;
        z_d        = z_q;
        mode_d     = mode_q;
        err_pend_d = err_pend_q;
        xo_d       = xo_q;
        yo_d       = yo_q;
        zo_d       = zo_q;
        err_d      = err_q;

        // The trig shortcut only applies to rotation. Vectoring always uses the supplied X/Y.
        xs_s  = (bus.trig && !bus.mode) ? ONE_W : W'(bus.x_in);
        ys_s  = (bus.trig && !bus.mode) ? {W{1'b0}} : W'(bus.y_in);
        zin_s = W'(bus.z_in);

        xsh_s   = x_q >>> k_q;
        ysh_s   = y_q >>> k_q;
        atan_s  = q28_to_w(atan_q28(k_q));
        d_pos_s = mode_q ? y_q[W-1] : !z_q[W-1];

        px_s    = PW'(x_q) * PW'(K_N);
        py_s    = PW'(y_q) * PW'(K_N);
        px_sh_s = px_s >>> (N - 4);
        py_sh_s = py_s >>> (N - 4);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d    = ITER;
                    k_d        = 5'd0;
                    mode_d     = bus.mode;
                    err_pend_d = !bus.mode && ((zin_s > PI_W) || (zin_s < -PI_W));
                    if (!bus.mode) begin
                        // Fold the angle into +-pi/2 so that the iterations can converge.
                        if (zin_s > HALF_PI_W) begin
                            x_d = -xs_s;
                            y_d = -ys_s;
                            z_d = zin_s - PI_W;
                        end else if (zin_s < -HALF_PI_W) begin
                            x_d = -xs_s;
                            y_d = -ys_s;
                            z_d = zin_s + PI_W;
                        end else begin
                            x_d = xs_s;
                            y_d = ys_s;
                            z_d = zin_s;
                        end
                    end else begin
                        // Move left half-plane vectors to the right half-plane. Z starts at +-pi.
                        if (xs_s[W-1]) begin
                            x_d = -xs_s;
                            y_d = -ys_s;
                            z_d = ys_s[W-1] ? -PI_W : PI_W;
                        end else begin
                            x_d = xs_s;
                            y_d = ys_s;
                            z_d = {W{1'b0}};
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                if (d_pos_s) begin
                    x_d = x_q - ysh_s;
                    y_d = y_q + xsh_s;
                    z_d = z_q - atan_s;
                end else begin
                    x_d = x_q + ysh_s;
                    y_d = y_q - xsh_s;
                    z_d = z_q + atan_s;
                end
                k_d = k_q + 5'd1;
                if (k_q == 5'(I - 1)) begin
                    state_d = SCALE;
                end else begin
                    state_d = ITER;
                end
            end
            SCALE: begin
                xo_d    = sat_n(px_sh_s);
                yo_d    = sat_n(py_sh_s);
                zo_d    = sat_n(PW'(z_q));
                err_d   = err_pend_q;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers. Reset overrides any accept or handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= 5'd0;
            x_q         <= {W{1'b0}};
            y_q         <= {W{1'b0}};
            z_q         <= {W{1'b0}};
            mode_q      <= 1'b0;
            err_pend_q  <= 1'b0;
            xo_q        <= {N{1'b0}};
            yo_q        <= {N{1'b0}};
            zo_q        <= {N{1'b0}};
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            mode_q      <= mode_d;
            err_pend_q  <= err_pend_d;
            xo_q        <= xo_d;
            yo_q        <= yo_d;
            zo_q        <= zo_d;
            err_q       <= err_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.x_out     = xo_q;
    assign bus.y_out     = yo_q;
    assign bus.z_out     = zo_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_cordic_iter.sv
// Directed bench for cordic_iter with N = 32 and I = 16.
// Expected results are hand-computed Q4.28 constants. Approximate results must lie within 2^-13.
module tb_cordic_iter;
    localparam int N = 32;
    localparam int I = 16;
    localparam longint TOL = 64'd32768;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic saw_valid;
    logic [31:0] hx, hy, hz;

    always #5 clk = ~clk;

    cordic_iter_if #(.N(N)) bus ();

    cordic_iter #(.N(N), .I(I)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        longint d;
        logic   ok;
        d = longint'($signed(obs)) - longint'($signed(exp));
        if (d < 0) d = -d;
        ok = (^obs !== 1'bx) && (d <= TOL);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (+-%0d)", tag, obs, exp, TOL);
        end
    endtask

    // Present the operands for one accept edge, then scramble the inputs while the operation is in flight.
    task automatic start_op(input logic m, input logic t, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] z);
        check_eq("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
        bus.mode = m; bus.trig = t; bus.x_in = x; bus.y_in = y; bus.z_in = z;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.mode = ~m; bus.trig = ~t;
        bus.x_in = $urandom(); bus.y_in = $urandom(); bus.z_in = $urandom();
    endtask

    // Count the edges after the accept edge until out_valid appears. The wait is bounded.
    task automatic wait_done();
        int edges;
        edges = 0;
        while (bus.out_valid !== 1'b1 && edges < 60) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check_eq("latency_cycles", edges + 1, I + 2);
    endtask

    task automatic release_op();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("out_valid_after_handshake", {31'd0, bus.out_valid}, 32'd0);
        check_eq("in_ready_after_handshake", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        // Reset with in_valid high. Reset must win over the accept.
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0; bus.mode = 1'b0; bus.trig = 1'b1;
        bus.x_in = 32'h0; bus.y_in = 32'h0; bus.z_in = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_eq("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("reset_x_out", bus.x_out, 32'h0);
        check_eq("reset_y_out", bus.y_out, 32'h0);
        check_eq("reset_z_out", bus.z_out, 32'h0);
        check_eq("reset_err", {31'd0, bus.err}, 32'd0);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Rotation with trig and z = 0. out_ready is high before DONE, so the handshake happens in the first DONE cycle.
        bus.out_ready = 1'b1;
        start_op(1'b0, 1'b1, 32'h0, 32'h0, 32'h00000000);
        check_eq("iter_out_valid_low", {31'd0, bus.out_valid}, 32'd0);
        check_eq("iter_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        wait_done();
        check_near("rot0_x", bus.x_out, 32'h10000000);
        check_near("rot0_y", bus.y_out, 32'h00000000);
        check_eq("rot0_err", {31'd0, bus.err}, 32'd0);
        release_op();

        // Rotation with trig and z = +pi/2.
        start_op(1'b0, 1'b1, 32'h0, 32'h0, 32'h1921FB54);
        wait_done();
        check_near("rot_hpi_x", bus.x_out, 32'h00000000);
        check_near("rot_hpi_y", bus.y_out, 32'h10000000);
        release_op();

        // Rotation with trig and z = -pi/2.
        start_op(1'b0, 1'b1, 32'h0, 32'h0, 32'hE6DE04AC);
        wait_done();
        check_near("rot_mhpi_x", bus.x_out, 32'h00000000);
        check_near("rot_mhpi_y", bus.y_out, 32'hF0000000);
        release_op();

        // Rotate (1.0, 0.5) by exactly pi. This is in range and gives (-1.0, -0.5).
        start_op(1'b0, 1'b0, 32'h10000000, 32'h08000000, 32'h3243F6A8);
        wait_done();
        check_near("rot_pi_x", bus.x_out, 32'hF0000000);
        check_near("rot_pi_y", bus.y_out, 32'hF8000000);
        check_eq("rot_pi_err", {31'd0, bus.err}, 32'd0);
        release_op();

        // Angle one LSB above pi must be flagged as out of range.
        start_op(1'b0, 1'b1, 32'h0, 32'h0, 32'h3243F6A9);
        wait_done();
        check_eq("rot_pi_plus_err", {31'd0, bus.err}, 32'd1);
        release_op();

        // Angle 4.0 must be flagged as out of range.
        start_op(1'b0, 1'b1, 32'h0, 32'h0, 32'h40000000);
        wait_done();
        check_eq("rot_4_err", {31'd0, bus.err}, 32'd1);
        release_op();

        // Vectoring (3, 4), with out_ready held low for 5 DONE cycles.
        bus.out_ready = 1'b0;
        start_op(1'b1, 1'b0, 32'h30000000, 32'h40000000, 32'h12345678);
        wait_done();
        check_near("vec34_x", bus.x_out, 32'h50000000);
        check_near("vec34_y", bus.y_out, 32'h00000000);
        check_near("vec34_z", bus.z_out, 32'h0ED63383);
        check_eq("vec34_err", {31'd0, bus.err}, 32'd0);
        hx = bus.x_out; hy = bus.y_out; hz = bus.z_out;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("stall_outputs_stable",
                     {31'd0, (bus.x_out === hx) && (bus.y_out === hy) && (bus.z_out === hz)
                             && (bus.out_valid === 1'b1)}, 32'd1);
            check_eq("stall_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        end
        release_op();

        // Vectoring (-1, 0). The result angle is +pi.
        start_op(1'b1, 1'b0, 32'hF0000000, 32'h00000000, 32'h0);
        wait_done();
        check_near("vecm1_x", bus.x_out, 32'h10000000);
        check_near("vecm1_z", bus.z_out, 32'h3243F6A8);
        release_op();

        // Vectoring (-1, -1). The magnitude is sqrt(2) and the angle is -3pi/4.
        start_op(1'b1, 1'b0, 32'hF0000000, 32'hF0000000, 32'h0);
        wait_done();
        check_near("vecm1m1_x", bus.x_out, 32'h16A09E66);
        check_near("vecm1m1_z", bus.z_out, 32'hDA4D0702);
        release_op();

        // Reset in the ITER cycle where k = 7. The operation must vanish without any out_valid pulse.
        saw_valid = 1'b0;
        start_op(1'b0, 1'b1, 32'h0, 32'h0, 32'h1921FB54);
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
            saw_valid = saw_valid | bus.out_valid;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("midreset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_eq("midreset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("midreset_x_out", bus.x_out, 32'h0);
        repeat (25) begin
            @(posedge clk);
            @(negedge clk);
            saw_valid = saw_valid | bus.out_valid;
        end
        check_eq("midreset_no_valid", {31'd0, saw_valid}, 32'd0);

        // The next operation after the reset must complete normally.
        start_op(1'b0, 1'b1, 32'h0, 32'h0, 32'h1921FB54);
        wait_done();
        check_near("post_reset_x", bus.x_out, 32'h00000000);
        check_near("post_reset_y", bus.y_out, 32'h10000000);
        release_op();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cordic_iter.md
CORDIC_ITER -- requirements
Module: cordic_iter

Interface
REQ-001 Parameters SHALL be:
- N, 32, data width; all data is signed Q4.(N-4), N in 16..32.
- I, 16, micro-rotation count, 1..28.
REQ-002 Ports SHALL be:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block can accept operands.
- mode  in  1  0 = rotation, 1 = vectoring.
- trig  in  1  rotation only: 1 = ignore x_in/y_in and use (1.0, 0).
- x_in  in  N  input X.
- y_in  in  N  input Y.
- z_in  in  N  input angle in radians; ignored in vectoring.
- out_valid  out  1  results valid.
- out_ready  in  1  consumer accepts results.
- x_out  out  N  rotation: cos or rotated X; vectoring: magnitude.
- y_out  out  N  rotation: sin or rotated Y; vectoring: residual, near 0.
- z_out  out  N  rotation: residual angle; vectoring: atan2(y_in, x_in).
- err  out  1  rotation angle out of range (see REQ-008).

Function
REQ-003 The FSM SHALL have four states: IDLE, ITER, SCALE and DONE.
REQ-004 in_ready SHALL be 1 only in IDLE; an accept is in_valid && in_ready on a rising edge.
REQ-005 On accept, the FSM SHALL go to ITER, clear the iteration counter k to 0, and register the operands after pre-rotation.
REQ-006 Rotation pre-rotation:
- If z_in > pi/2: negate X and Y, and set Z = z_in - pi.
- If z_in < -pi/2: negate X and Y, and set Z = z_in + pi.
- Otherwise pass X, Y and Z unchanged.
REQ-007 Vectoring pre-rotation:
- If x_in < 0 and y_in >= 0: negate X and Y, and set Z = +pi.
- If x_in < 0 and y_in < 0: negate X and Y, and set Z = -pi.
- Otherwise set Z = 0.
REQ-008 In rotation mode, err SHALL be set when z_in < -pi or z_in > pi; the iterations still run and the outputs are don't-care.
REQ-009 Each ITER cycle SHALL perform one micro-rotation with shift k and then increment k; the direction d is sign(Z) in rotation and -sign(Y) in vectoring.
REQ-010 Shifts SHALL be arithmetic.
REQ-011 The X, Y and Z registers SHALL be N+2 bits wide (2 guard integer bits).
REQ-012 The atan(2^-k) table SHALL hold Q4.(N-4) constants for k = 0..27, truncated from their Q4.28 values.
REQ-013 After the iteration with k = I-1, the FSM SHALL go to SCALE.
REQ-014 SCALE SHALL multiply X and Y by K = 0.6072529350 (Q4.28 0x09B74EDA, truncated to N) in one cycle:
- The product is arithmetic-shifted right by N-4 (truncation).
- The result is saturated to the N-bit signed range.
- Z is passed unscaled, saturated to N bits.
REQ-015 DONE SHALL assert out_valid and hold x_out, y_out, z_out and err stable until out_valid && out_ready.
REQ-016 When out_valid && out_ready, the FSM SHALL go to IDLE.
REQ-017 Latency SHALL be exactly I+2 cycles from the accept edge to the first cycle with out_valid = 1.
REQ-018 Throughput SHALL be at most one operation per I+3 cycles.
REQ-019 out_ready = 1 on the first DONE cycle SHALL complete the handshake in that cycle, and in_ready SHALL be 1 on the next cycle.
REQ-020 Inputs SHALL be sampled only on the accept edge; later changes to the inputs SHALL NOT affect an operation in flight.
REQ-021 Outputs SHALL be registered; x_out, y_out, z_out and err SHALL change only on entry to DONE or on reset.

Reset
REQ-022 While rst = 1, on each rising edge the block SHALL:
- go to IDLE;
- clear k;
- set in_ready to 1 from the next cycle, and out_valid to 0;
- set x_out, y_out, z_out and err to 0.
REQ-023 Reset SHALL take priority over all other events, including an accept or an output handshake on the same edge.
REQ-024 Reset asserted mid-ITER or mid-DONE SHALL discard the operation with no out_valid pulse.

Verification
REQ-025 Accuracy tolerance: a result is correct when |error| <= 2^-(I-3) in real units (I <= 24, N = 32).
REQ-026 The bench SHALL cover the following directed scenarios:
- Rotation, trig = 1, z_in = 0 -> out_valid at accept+18 (I = 16); x_out ~= 0x10000000, y_out ~= 0.
- Rotation, trig = 1, z_in = 0x1921FB54 (pi/2) -> x_out ~= 0, y_out ~= 0x10000000.
- Rotation, trig = 1, z_in = 0xE6DE04AC (-pi/2) -> x_out ~= 0, y_out ~= 0xF0000000.
- Vectoring, x_in = 3.0 (0x30000000), y_in = 4.0 (0x40000000) -> x_out ~= 5.0 (0x50000000), z_out ~= 0.927295 (0x0ED63383).
- Vectoring, x_in = -1.0, y_in = 0 -> x_out ~= 1.0, z_out ~= +pi (0x3243F6A8).
- Rotation, z_in = 4.0 -> err = 1 in DONE.
- out_ready held 0 for 5 cycles in DONE -> outputs stable and in_ready = 0 throughout; in_ready = 1 the cycle after out_ready rises.
- rst pulsed at ITER k = 7 -> next cycle in IDLE, out_valid never asserted; a following operation completes correctly.
